// File: rtl/cmos_in_axi4s_stream_ctrl_pkg.sv
// Shared definitions for the CMOS-input AXI4-Stream controller:
// FSM state encoding and the layout of the FIFO word {field_id, sof, eol, data}.
package cmos_in_axi4s_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_STREAM   = 2'd1,
    ST_RESYNC   = 2'd2
  } state_e;

  // Data sits at the bottom of the word; the flag offsets are counted from the data width.
  localparam int DATA_LSB  = 0;
  localparam int EOL_OFS   = 0;
  localparam int SOF_OFS   = 1;
  localparam int FIELD_OFS = 2;

  function automatic int flag_bit(input int data_w, input int ofs);
    return data_w + ofs;
  endfunction

endpackage

// File: rtl/cmos_in_axi4s_stream_ctrl.sv
// Frame-synchronising bridge from a first-word-fall-through pixel FIFO to an
// AXI4-Stream video master, with capture gating, overflow resync and frame/drop counters.
module cmos_in_axi4s_stream_ctrl
  import cmos_in_axi4s_stream_ctrl_pkg::*;
#(
  parameter int C_NATIVE_DATA_WIDTH = 24,
  parameter int C_CNT_WIDTH         = 16
) (
  input  logic                           VID_IN_CLK,
  input  logic                           VID_RESET,
  input  logic [C_NATIVE_DATA_WIDTH+2:0] FIFO_RD_DATA,
  input  logic                           FIFO_EMPTY,
  output logic                           FIFO_RD_EN,
  input  logic                           FIFO_OVERFLOW,
  input  logic                           CAPTURE_EN,
  input  logic                           SINGLE_SHOT,
  output logic [C_NATIVE_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  output logic                           M_AXIS_TUSER,
  output logic                           M_AXIS_TLAST,
  output logic [C_CNT_WIDTH-1:0]         FRAME_CNT,
  output logic [C_CNT_WIDTH-1:0]         DROP_CNT,
  output logic                           SYNCED,
  output logic                           OVF_STICKY,
  input  logic                           OVF_CLR
);

  localparam int EOL_BIT   = flag_bit(C_NATIVE_DATA_WIDTH, EOL_OFS);
  localparam int SOF_BIT   = flag_bit(C_NATIVE_DATA_WIDTH, SOF_OFS);
  localparam int FIELD_BIT = flag_bit(C_NATIVE_DATA_WIDTH, FIELD_OFS);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  state_e                         state_q, state_d;
  logic                           armed_q, armed_d;
  logic                           synced_q, synced_d;
  logic                           ovf_q, ovf_d;
  logic                           tvalid_q, tvalid_d;
  logic                           tuser_q, tuser_d;
  logic                           tlast_q, tlast_d;
  logic [C_NATIVE_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [C_CNT_WIDTH-1:0]         frame_cnt_q, frame_cnt_d;
  logic [C_CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d;

  logic word_sof_s, word_eol_s, gate_open_s, out_free_s;
  logic rd_en_s, fwd_s, drop_s, consume_s;
  logic unused_field_s;

  assign word_sof_s     = FIFO_RD_DATA[SOF_BIT];
  assign word_eol_s     = FIFO_RD_DATA[EOL_BIT];
  assign unused_field_s = FIFO_RD_DATA[FIELD_BIT];
  assign gate_open_s    = CAPTURE_EN | armed_q;
  assign out_free_s     = ~tvalid_q | M_AXIS_TREADY;

  // Pop/forward/drop decision and next state; an sof that would be forwarded
  // waits for a free output slot so a held beat is never overwritten.
  always_comb begin
    state_d   = state_q;
    rd_en_s   = 1'b0;
    fwd_s     = 1'b0;
    drop_s    = 1'b0;
    consume_s = 1'b0;
    case (state_q)
      ST_STREAM: begin
        if (!FIFO_EMPTY && out_free_s) begin
          rd_en_s = 1'b1;
          if (word_sof_s && !gate_open_s) begin
            drop_s  = 1'b1;
            state_d = ST_WAIT_SOF;
          end else begin
            fwd_s     = 1'b1;
            consume_s = word_sof_s & ~CAPTURE_EN;
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      ST_WAIT_SOF, ST_RESYNC: begin
        if (FIFO_EMPTY) begin
          rd_en_s = 1'b0;
        end else if (!word_sof_s) begin
          rd_en_s = 1'b1;
        end else if (!gate_open_s) begin
          rd_en_s = 1'b1;
          drop_s  = 1'b1;
          state_d = ST_WAIT_SOF;
        end else if (out_free_s) begin
          rd_en_s   = 1'b1;
          fwd_s     = 1'b1;
          consume_s = ~CAPTURE_EN;
          state_d   = ST_STREAM;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_WAIT_SOF;
      end
    endcase
    if (FIFO_OVERFLOW) begin
      state_d = ST_RESYNC;
    end else begin
      state_d = state_d;
    end
  end

  // Output register, single-shot arming, sticky overflow flag and counters.
  always_comb begin
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    armed_d     = armed_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    synced_d    = (state_d == ST_STREAM);
    if (fwd_s) begin
      tvalid_d = 1'b1;
      tdata_d  = FIFO_RD_DATA[DATA_LSB +: C_NATIVE_DATA_WIDTH];
      tuser_d  = word_sof_s;
      tlast_d  = word_eol_s;
    end else if (M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
    // A new SINGLE_SHOT wins over a same-cycle disarm.
    if (SINGLE_SHOT) begin
      armed_d = 1'b1;
    end else if (consume_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    if (FIFO_OVERFLOW) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (tvalid_q && M_AXIS_TREADY && tuser_q) begin
      frame_cnt_d = frame_cnt_q + CNT_ONE;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (drop_s) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and output flops with synchronous reset.
  always_ff @(posedge VID_IN_CLK) begin
    if (VID_RESET) begin
      state_q     <= ST_WAIT_SOF;
      armed_q     <= 1'b0;
      synced_q    <= 1'b0;
      ovf_q       <= 1'b0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      synced_q    <= synced_d;
      ovf_q       <= ovf_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // The pop strobe must act on the word currently shown by the FIFO, so it stays combinational.
  assign FIFO_RD_EN    = rd_en_s & ~VID_RESET;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign FRAME_CNT     = frame_cnt_q;
  assign DROP_CNT      = drop_cnt_q;
  assign SYNCED        = synced_q;
  assign OVF_STICKY    = ovf_q;

endmodule

// File: tb/tb_cmos_in_axi4s_stream_ctrl.sv
// Self-checking bench: FIFO model feeding the DUT, frame-level reference model
// and scoreboard on the AXI4-Stream side, plus directed corner-case sequences.
module tb_cmos_in_axi4s_stream_ctrl;

  localparam int W   = 24;
  localparam int CW  = 16;
  localparam int WW  = W + 3;
  localparam int EOL = W;
  localparam int SOF = W + 1;
  localparam int FID = W + 2;

  logic          clk = 1'b0;
  logic          VID_RESET, FIFO_EMPTY, FIFO_RD_EN, FIFO_OVERFLOW;
  logic          CAPTURE_EN, SINGLE_SHOT, OVF_CLR;
  logic [WW-1:0] FIFO_RD_DATA;
  logic [W-1:0]  M_AXIS_TDATA;
  logic          M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TUSER, M_AXIS_TLAST;
  logic [CW-1:0] FRAME_CNT, DROP_CNT;
  logic          SYNCED, OVF_STICKY;

  always #5 clk = ~clk;

  cmos_in_axi4s_stream_ctrl #(.C_NATIVE_DATA_WIDTH(W), .C_CNT_WIDTH(CW)) dut (
    .VID_IN_CLK(clk), .VID_RESET(VID_RESET),
    .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_EN(FIFO_RD_EN),
    .FIFO_OVERFLOW(FIFO_OVERFLOW), .CAPTURE_EN(CAPTURE_EN), .SINGLE_SHOT(SINGLE_SHOT),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
    .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT), .SYNCED(SYNCED),
    .OVF_STICKY(OVF_STICKY), .OVF_CLR(OVF_CLR)
  );

  typedef struct {
    logic ovf;
    logic clr;
    logic exp_sticky;
  } vec_t;

  logic [WW-1:0] fifo[$];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] buf_q[$];
  int checks = 0;
  int errors = 0;

  // reference-model state: frame-level view of the word stream
  bit m_cap, m_armed, m_in_frame;
  int m_frames, m_drops;

  bit rdy_rand, rdy_val, gap_en;
  bit prev_stall;
  logic [W+1:0] prev_beat;
  int cyc, first_pop, first_vld, hs_cnt, tuser_cnt, tlast_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply();
    bit gap;
    gap = gap_en ? ($urandom_range(3) == 0) : 1'b0;
    FIFO_EMPTY    = (fifo.size() == 0) || gap;
    FIFO_RD_DATA  = (fifo.size() != 0) ? fifo[0] : '0;
    M_AXIS_TREADY = rdy_rand ? 1'($urandom_range(1)) : rdy_val;
  endtask

  // Decide the fate of a word from the frame rules alone, in FIFO order.
  task automatic model_word(input logic [WW-1:0] w);
    if (w[SOF]) begin
      if (m_cap || m_armed) begin
        exp_q.push_back(w);
        m_in_frame = 1'b1;
        m_frames++;
        if (!m_cap) m_armed = 1'b0;
      end else begin
        m_drops++;
        m_in_frame = 1'b0;
      end
    end else if (m_in_frame) begin
      exp_q.push_back(w);
    end
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    fifo.push_back(w);
    model_word(w);
    apply();
  endtask

  task automatic build_frame(input int lines, input int px);
    logic [WW-1:0] w;
    buf_q.delete();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        w        = '0;
        w[W-1:0] = W'($urandom);
        w[SOF]   = (l == 0 && p == 0);
        w[EOL]   = (p == px - 1);
        w[FID]   = 1'($urandom_range(1));
        buf_q.push_back(w);
      end
    end
  endtask

  task automatic push_buf(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_word(buf_q[i]);
  endtask

  task automatic push_frame(input int lines, input int px);
    build_frame(lines, px);
    push_buf(0, lines * px - 1);
  endtask

  // One clock: sample at negedge, then retire pops and refresh inputs after the edge.
  task automatic cycle();
    logic pop, hs, rst;
    logic [W+1:0] beat;
    logic [WW-1:0] w;
    @(negedge clk);
    cyc++;
    pop  = FIFO_RD_EN;
    rst  = VID_RESET;
    hs   = M_AXIS_TVALID & M_AXIS_TREADY;
    beat = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
    chk("rd_en_while_empty", 64'(pop & FIFO_EMPTY), 64'(0));
    if (prev_stall) begin
      chk("stall_tvalid", 64'(M_AXIS_TVALID), 64'(1));
      chk("stall_beat", 64'(beat), 64'(prev_beat));
    end
    if (pop && first_pop < 0) first_pop = cyc;
    if (M_AXIS_TVALID && first_vld < 0) first_vld = cyc;
    if (hs) begin
      hs_cnt++;
      if (M_AXIS_TUSER) tuser_cnt++;
      if (M_AXIS_TLAST) tlast_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", beat);
      end else begin
        w = exp_q.pop_front();
        chk("beat", 64'(beat), 64'({w[SOF], w[EOL], w[W-1:0]}));
      end
    end
    prev_stall = M_AXIS_TVALID & ~M_AXIS_TREADY & ~rst;
    prev_beat  = beat;
    @(posedge clk);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    apply();
  endtask

  task automatic clear_stats();
    first_pop = -1; first_vld = -1; hs_cnt = 0; tuser_cnt = 0; tlast_cnt = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_in_frame = 1'b0; m_armed = 1'b0; m_frames = 0; m_drops = 0;
    prev_stall = 1'b0;
    clear_stats();
  endtask

  task automatic do_reset();
    VID_RESET = 1'b1;
    cycle();
    VID_RESET = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo.size() != 0 || M_AXIS_TVALID) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'(1));
    chk("no_lost_beats", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_single_shot();
    SINGLE_SHOT = 1'b1;
    m_armed     = 1'b1;
    cycle();
    SINGLE_SHOT = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    bit found;
    tbl[0] = '{1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0};

    VID_RESET = 1'b1; FIFO_OVERFLOW = 1'b0; CAPTURE_EN = 1'b0; SINGLE_SHOT = 1'b0;
    OVF_CLR = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1; gap_en = 1'b0; m_cap = 1'b0;
    cyc = 0;
    model_reset();
    apply();

    // reset state
    cycle();
    cycle();
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("rst_tuser", 64'(M_AXIS_TUSER), 64'(0));
    chk("rst_tlast", 64'(M_AXIS_TLAST), 64'(0));
    chk("rst_tdata", 64'(M_AXIS_TDATA), 64'(0));
    chk("rst_frame_cnt", 64'(FRAME_CNT), 64'(0));
    chk("rst_drop_cnt", 64'(DROP_CNT), 64'(0));
    chk("rst_synced", 64'(SYNCED), 64'(0));
    chk("rst_ovf", 64'(OVF_STICKY), 64'(0));
    VID_RESET = 1'b0;

    // sticky overflow flag table
    for (int i = 0; i < 8; i++) begin
      FIFO_OVERFLOW = tbl[i].ovf;
      OVF_CLR       = tbl[i].clr;
      cycle();
      FIFO_OVERFLOW = 1'b0;
      OVF_CLR       = 1'b0;
      chk($sformatf("ovf_tbl_%0d", i), 64'(OVF_STICKY), 64'(tbl[i].exp_sticky));
    end

    // continuous capture, 3 frames of 4x8, TREADY=1
    do_reset();
    CAPTURE_EN = 1'b1; m_cap = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(4, 8);
    repeat (97) cycle();
    chk("full_rate_beats", 64'(hs_cnt), 64'(96));
    chk("latency", 64'(first_vld - first_pop), 64'(1));
    chk("synced_streaming", 64'(SYNCED), 64'(1));
    drain(50);
    chk("tuser_count", 64'(tuser_cnt), 64'(3));
    chk("tlast_count", 64'(tlast_cnt), 64'(12));
    chk("frame_cnt_3", 64'(FRAME_CNT), 64'(3));
    chk("drop_cnt_0", 64'(DROP_CNT), 64'(0));

    // single shot (pulsed twice while armed), 3 frames
    do_reset();
    CAPTURE_EN = 1'b0; m_cap = 1'b0;
    pulse_single_shot();
    pulse_single_shot();
    for (int f = 0; f < 3; f++) push_frame(4, 8);
    drain(400);
    chk("ss_frame_cnt", 64'(FRAME_CNT), 64'(1));
    chk("ss_drop_cnt", 64'(DROP_CNT), 64'(2));

    // randomized rounds: random TREADY, FIFO gaps, capture mode, single shots, junk
    do_reset();
    rdy_rand = 1'b1; gap_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      m_cap      = (r == 0) ? 1'b1 : 1'($urandom_range(1));
      CAPTURE_EN = m_cap;
      if ($urandom_range(1) == 1) pulse_single_shot();
      for (int j = 0; j < int'($urandom_range(3)); j++) push_word(WW'($urandom) & ~(WW'(1) << SOF));
      for (int f = 0; f < int'($urandom_range(1, 3)); f++)
        push_frame(int'($urandom_range(1, 3)), int'($urandom_range(2, 6)));
      drain(4000);
      chk($sformatf("rnd_frame_cnt_%0d", r), 64'(FRAME_CNT), 64'(CW'(m_frames)));
      chk($sformatf("rnd_drop_cnt_%0d", r), 64'(DROP_CNT), 64'(CW'(m_drops)));
    end
    rdy_rand = 1'b0; gap_en = 1'b0; rdy_val = 1'b1;

    // overflow in line 2 of frame 1
    do_reset();
    CAPTURE_EN = 1'b1; m_cap = 1'b1;
    build_frame(4, 8);
    push_buf(0, 10);
    drain(50);
    chk("ovf_pre_synced", 64'(SYNCED), 64'(1));
    FIFO_OVERFLOW = 1'b1;
    cycle();
    FIFO_OVERFLOW = 1'b0;
    m_in_frame = 1'b0;
    chk("ovf_sticky_set", 64'(OVF_STICKY), 64'(1));
    chk("ovf_resync", 64'(SYNCED), 64'(0));
    push_buf(11, 31);
    push_frame(4, 8);
    drain(200);
    chk("ovf_frame_cnt", 64'(FRAME_CNT), 64'(2));
    chk("ovf_drop_cnt", 64'(DROP_CNT), 64'(0));
    OVF_CLR = 1'b1;
    cycle();
    OVF_CLR = 1'b0;
    chk("ovf_clr", 64'(OVF_STICKY), 64'(0));

    // reset mid-line with a stalled beat
    do_reset();
    rdy_val = 1'b0;
    push_frame(4, 8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = M_AXIS_TVALID;
    end
    chk("stall_beat_seen", 64'(found), 64'(1));
    cycle();
    cycle();
    do_reset();
    chk("mid_rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
    chk("mid_rst_frame_cnt", 64'(FRAME_CNT), 64'(0));
    chk("mid_rst_drop_cnt", 64'(DROP_CNT), 64'(0));
    chk("mid_rst_synced", 64'(SYNCED), 64'(0));
    rdy_val = 1'b1;
    push_frame(4, 8);
    drain(200);
    chk("post_rst_frame_cnt", 64'(FRAME_CNT), 64'(1));
    chk("post_rst_first_tuser", 64'(tuser_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmos_in_axi4s_stream_ctrl.md
CMOS_IN_AXI4S_STREAM_CTRL -- requirements
Module: cmos_in_axi4s_stream_ctrl

Interface
REQ-001 SHALL have parameter C_NATIVE_DATA_WIDTH, default 24, pixel data width.
REQ-002 SHALL have parameter C_CNT_WIDTH, default 16, width of frame and drop counters.
REQ-003 VID_IN_CLK  in  1  sole clock; all logic on its rising edge.
REQ-004 VID_RESET  in  1  synchronous, active-high reset.
REQ-005 FIFO_RD_DATA  in  C_NATIVE_DATA_WIDTH+3  first-word-fall-through word {field_id, sof, eol, data}, valid while FIFO_EMPTY=0.
REQ-006 FIFO_EMPTY  in  1  FIFO holds no word.
REQ-007 FIFO_RD_EN  out  1  pops the current FIFO word this cycle.
REQ-008 FIFO_OVERFLOW  in  1  single-cycle pulse: write side lost a word.
REQ-009 CAPTURE_EN  in  1  level; continuous capture enable.
REQ-010 SINGLE_SHOT  in  1  pulse; arms capture of exactly one frame.
REQ-011 M_AXIS_TDATA  out  C_NATIVE_DATA_WIDTH  pixel data.
REQ-012 M_AXIS_TVALID / M_AXIS_TREADY  out / in  1 each  AXI4-Stream handshake.
REQ-013 M_AXIS_TUSER  out  1  start of frame (word's sof bit).
REQ-014 M_AXIS_TLAST  out  1  end of line (word's eol bit).
REQ-015 FRAME_CNT / DROP_CNT  out  C_CNT_WIDTH each  frames forwarded / frames discarded.
REQ-016 SYNCED  out  1  high while in STREAM state.
REQ-017 OVF_STICKY  out  1  set by FIFO_OVERFLOW; cleared by OVF_CLR (in, 1) pulse.

Function
REQ-018 States SHALL be WAIT_SOF, STREAM, RESYNC.
REQ-019 Gate: open at an sof word if CAPTURE_EN=1 or single-shot is armed; consuming an armed single-shot disarms it.
REQ-020 WAIT_SOF: pop one word per cycle while FIFO_EMPTY=0, regardless of TREADY.
- Non-sof words are discarded.
- sof word with gate open: forward it, go STREAM.
- sof word with gate closed: discard it, DROP_CNT+1, stay.
REQ-021 STREAM: pop and load the output register only when FIFO_EMPTY=0 and (TVALID=0 or TREADY=1).
- A mid-stream sof word re-evaluates the gate.
- Gate closed: discard it, DROP_CNT+1, go WAIT_SOF.
REQ-022 FIFO_OVERFLOW in any state SHALL:
- go RESYNC next cycle (overrides any same-cycle transition);
- set OVF_STICKY.
REQ-023 RESYNC: discard words as in WAIT_SOF until an sof word, which is then handled as in WAIT_SOF.
REQ-024 A beat already in the output register when leaving STREAM SHALL still be held until TREADY.
REQ-025 Latency: FIFO word popped in cycle N SHALL appear on TVALID/TDATA in cycle N+1.
REQ-026 Throughput: one beat per cycle while TREADY=1 and FIFO non-empty.
REQ-027 TVALID SHALL NOT drop, and TDATA/TUSER/TLAST SHALL NOT change, while TVALID=1 and TREADY=0.
REQ-028 FRAME_CNT SHALL increment on TVALID&TREADY&TUSER; both counters wrap modulo 2^C_CNT_WIDTH.
REQ-029 SINGLE_SHOT while already armed: no effect; arm and disarm in the same cycle: remains armed.
REQ-030 OVF_CLR and FIFO_OVERFLOW in the same cycle: OVF_STICKY = 1.
REQ-031 FIFO_RD_EN SHALL never assert while FIFO_EMPTY=1.

Reset
REQ-032 VID_RESET SHALL, next edge, force:
- WAIT_SOF; single-shot disarmed;
- TVALID, TUSER, TLAST, FIFO_RD_EN, SYNCED, OVF_STICKY = 0;
- TDATA, FRAME_CNT, DROP_CNT = 0.
REQ-033 Reset mid-frame SHALL discard the held output beat; the first beat after reset carries TUSER=1.

Structure
REQ-034 Shared package holds:
- state encoding;
- FIFO word bit-offset constants (field_id, sof, eol, data LSB).
REQ-035 Single module, no sub-modules; the output register is the only data stage.

Verification
REQ-036 CAPTURE_EN=1, 3 frames of 4 lines × 8 px, TREADY=1 -> 96 beats, TUSER on beats 1/33/65, TLAST every 8th beat, FRAME_CNT=3.
REQ-037 CAPTURE_EN=0, SINGLE_SHOT pulse, 3 frames -> only frame 1 forwarded, FRAME_CNT=1, DROP_CNT=2.
REQ-038 Random TREADY (50%) over 1 frame -> output equals input order, no beat lost or duplicated, TDATA stable while stalled.
REQ-039 FIFO_OVERFLOW at line 2 of frame 1 -> rest of frame 1 discarded, OVF_STICKY=1, frame 2 streams from its sof.
REQ-040 VID_RESET mid-line with TVALID=1, TREADY=0 -> TVALID=0 next cycle, counters 0, streaming resumes at next sof.
